load_store_unit: RTL

Multi-cycle data-memory access engine between the `memory` pipeline stage and the word-organised `ram`. It accepts one load or store request at a time, using RISC-V width encoding in `funct3`. Byte and halfword stores are performed as read-modify-write, because `ram` has no byte enables. Loaded data is aligned and sign- or zero-extended, and completion is reported with a one-cycle `mem_done` pulse, which the `memory` stage forwards to `writeback`.

---
 rtl/load_store_unit.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store engine between the memory stage and a word-wide RAM.
// Sub-word stores are done as read-modify-write because the RAM has no byte enables.
module load_store_unit #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic [31:0] mem_read_data,
    output logic [31:0] data_out,
    output logic        mem_done,
    output logic        fault,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t      state_r;
    logic [1:0]  lat_cnt_r;
    logic [1:0]  off_r;
    logic [2:0]  funct3_r;
    logic [15:0] store_data_r;
    logic        is_store_r;

    logic        req_take_s;
    logic        req_fault_s;
    logic        req_sw_s;

    // Rejects conflicting ops, unknown widths, unsigned stores and misaligned accesses.
    function automatic logic access_fault(
        input logic       rd,
        input logic       wr,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = off[0];
            F3_W:    bad = (off != 2'b00);
            F3_BU:   bad = wr;
            F3_HU:   bad = wr | off[0];
            default: bad = 1'b1;
        endcase
        return bad | (rd & wr);
    endfunction

    function automatic logic [31:0] extract_load(
        input logic [31:0] word,
        input logic [2:0]  f3,
        input logic [1:0]  off
    );
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] res;
        case (off)
            2'b00:   lane_b = word[7:0];
            2'b01:   lane_b = word[15:8];
            2'b10:   lane_b = word[23:16];
            2'b11:   lane_b = word[31:24];
            default: lane_b = 8'h00;
        endcase
        if (off[1]) begin
            lane_h = word[31:16];
        end else begin
            lane_h = word[15:0];
        end
        case (f3)
            F3_B:    res = {{24{lane_b[7]}}, lane_b};
            F3_H:    res = {{16{lane_h[15]}}, lane_h};
            F3_W:    res = word;
            F3_BU:   res = {24'h000000, lane_b};
            F3_HU:   res = {16'h0000, lane_h};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Only the addressed lane takes new data; the rest keeps the word just read.
    function automatic logic [31:0] merge_store(
        input logic [31:0] word,
        input logic [15:0] sdata,
        input logic [2:0]  f3,
        input logic [1:0]  off
    );
        logic [31:0] res;
        res = word;
        case (f3)
            F3_B: begin
                case (off)
                    2'b00:   res = {word[31:8], sdata[7:0]};
                    2'b01:   res = {word[31:16], sdata[7:0], word[7:0]};
                    2'b10:   res = {word[31:24], sdata[7:0], word[15:0]};
                    2'b11:   res = {sdata[7:0], word[23:0]};
                    default: res = word;
                endcase
            end
            F3_H: begin
                if (off[1]) begin
                    res = {sdata, word[15:0]};
                end else begin
                    res = {word[31:16], sdata};
                end
            end
            default: res = word;
        endcase
        return res;
    endfunction

    // Request decode, only meaningful while idle.
    always_comb begin
        req_take_s  = 1'b0;
        req_fault_s = access_fault(MemRead, MemWrite, funct3, addr[1:0]);
        req_sw_s    = 1'b0;
        if ((state_r == IDLE) && req && (MemRead || MemWrite)) begin
            req_take_s = 1'b1;
        end else begin
            req_take_s = 1'b0;
        end
        if (MemWrite && !MemRead && (funct3 == F3_W)) begin
            req_sw_s = 1'b1;
        end else begin
            req_sw_s = 1'b0;
        end
    end

    // Access sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r          <= IDLE;
            lat_cnt_r        <= 2'b00;
            off_r            <= 2'b00;
            funct3_r         <= 3'b000;
            store_data_r     <= 16'h0000;
            is_store_r       <= 1'b0;
            data_out         <= 32'h0000_0000;
            mem_done         <= 1'b0;
            fault            <= 1'b0;
            busy             <= 1'b0;
            mem_addr         <= 32'h0000_0000;
            mem_write_data   <= 32'h0000_0000;
            mem_write_enable <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    mem_done         <= 1'b0;
                    fault            <= 1'b0;
                    mem_write_enable <= 1'b0;
                    if (req_take_s) begin
                        off_r        <= addr[1:0];
                        funct3_r     <= funct3;
                        store_data_r <= data_in[15:0];
                        is_store_r   <= MemWrite;
                        lat_cnt_r    <= 2'b00;
                        busy         <= 1'b1;
                        if (req_fault_s) begin
                            state_r  <= DONE;
                            mem_done <= 1'b1;
                            fault    <= 1'b1;
                            data_out <= 32'h0000_0000;
                        end else if (req_sw_s) begin
                            state_r          <= WR;
                            mem_addr         <= {2'b00, addr[31:2]};
                            mem_write_data   <= data_in;
                            mem_write_enable <= 1'b1;
                        end else begin
                            state_r  <= RD;
                            mem_addr <= {2'b00, addr[31:2]};
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RD: begin
                    if (lat_cnt_r == LAT_LAST) begin
                        if (is_store_r) begin
                            state_r          <= WR;
                            mem_write_data   <= merge_store(mem_read_data, store_data_r, funct3_r, off_r);
                            mem_write_enable <= 1'b1;
                        end else begin
                            state_r  <= DONE;
                            data_out <= extract_load(mem_read_data, funct3_r, off_r);
                            mem_done <= 1'b1;
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r + 2'b01;
                    end
                end
                WR: begin
                    state_r          <= DONE;
                    mem_write_enable <= 1'b0;
                    mem_done         <= 1'b1;
                end
                DONE: begin
                    state_r  <= IDLE;
                    mem_done <= 1'b0;
                    fault    <= 1'b0;
                    busy     <= 1'b0;
                end
                default: begin
                    state_r          <= IDLE;
                    mem_done         <= 1'b0;
                    fault            <= 1'b0;
                    busy             <= 1'b0;
                    mem_write_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule
